// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory bus between fetch (F, read-only) and mem stage (M, load/store).
// M has priority, bounded by an F starvation counter; a watchdog aborts transactions that never ack.
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int MAX_F_WAIT = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_f_req,
  input  logic [XLEN-1:0]   i_f_addr,
  output logic [XLEN-1:0]   o_f_rdata,
  output logic              o_f_done,
  input  logic              i_m_req,
  input  logic              i_m_we,
  input  logic [XLEN-1:0]   i_m_addr,
  input  logic [XLEN-1:0]   i_m_wdata,
  input  logic [XLEN/8-1:0] i_m_be,
  output logic [XLEN-1:0]   o_m_rdata,
  output logic              o_m_done,
  output logic              o_err,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [XLEN-1:0]   o_bus_addr,
  output logic [XLEN-1:0]   o_bus_wdata,
  output logic [XLEN/8-1:0] o_bus_be,
  input  logic              i_bus_ack,
  input  logic [XLEN-1:0]   i_bus_rdata,
  output logic              o_busy
);

  localparam int FW   = $clog2(MAX_F_WAIT + 1);
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, BUS_F, BUS_M, DONE} state_t;

  state_t        state, state_n;
  logic [FW-1:0] f_wait;
  logic [TW-1:0] tcnt;
  logic          grant_f, grant_m, wd_fire, f_forced;

  // tcnt holds the number of bus cycles already elapsed before this one
  assign wd_fire  = (TIMEOUT > 0) && (tcnt == TW'(TLIM));
  assign f_forced = (f_wait == FW'(MAX_F_WAIT));

  always_comb begin
    state_n = state;
    grant_f = 1'b0;
    grant_m = 1'b0;
    case (state)
      IDLE: begin
        if (i_f_req && (!i_m_req || f_forced)) grant_f = 1'b1;
        else if (i_m_req)                      grant_m = 1'b1;
        if (grant_f)      state_n = BUS_F;
        else if (grant_m) state_n = BUS_M;
      end
      BUS_F, BUS_M: if (i_bus_ack || wd_fire) state_n = DONE;
      default:      state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      f_wait      <= '0;
      tcnt        <= '0;
      o_f_rdata   <= '0;
      o_f_done    <= 1'b0;
      o_m_rdata   <= '0;
      o_m_done    <= 1'b0;
      o_err       <= 1'b0;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
      o_bus_be    <= '0;
      o_busy      <= 1'b0;
    end else begin
      state    <= state_n;
      o_busy   <= (state_n != IDLE);
      o_f_done <= 1'b0;
      o_m_done <= 1'b0;
      o_err    <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (grant_f) begin
            f_wait      <= '0;
            o_bus_req   <= 1'b1;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= i_f_addr;
            o_bus_wdata <= '0;
            o_bus_be    <= '1;
          end else if (grant_m) begin
            if (i_f_req && !f_forced) f_wait <= f_wait + 1'b1;
            o_bus_req   <= 1'b1;
            o_bus_we    <= i_m_we;
            o_bus_addr  <= i_m_addr;
            o_bus_wdata <= i_m_wdata;
            o_bus_be    <= i_m_be;
          end
        end
        BUS_F, BUS_M: begin
          if (i_bus_ack || wd_fire) begin
            // ack beats a simultaneous watchdog expiry
            o_bus_req <= 1'b0;
            o_err     <= !i_bus_ack;
            if (state == BUS_F) begin
              o_f_done  <= 1'b1;
              o_f_rdata <= i_bus_ack ? i_bus_rdata : '0;
            end else begin
              o_m_done  <= 1'b1;
              o_m_rdata <= (i_bus_ack && !o_bus_we) ? i_bus_rdata : '0;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single-port reads, M priority, fetch anti-starvation,
// watchdog abort and ack-on-expiry, stray ack, async reset mid-transaction.
module tb_mem_port_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_f_req, i_m_req, i_m_we, i_bus_ack;
  logic [31:0] i_f_addr, i_m_addr, i_m_wdata, i_bus_rdata;
  logic [3:0]  i_m_be;
  logic [31:0] o_f_rdata, o_m_rdata, o_bus_addr, o_bus_wdata;
  logic        o_f_done, o_m_done, o_err, o_bus_req, o_bus_we, o_busy;
  logic [3:0]  o_bus_be;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt;

  mem_port_arbiter #(.XLEN(32), .MAX_F_WAIT(4), .TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_f_req(i_f_req), .i_f_addr(i_f_addr), .o_f_rdata(o_f_rdata), .o_f_done(o_f_done),
    .i_m_req(i_m_req), .i_m_we(i_m_we), .i_m_addr(i_m_addr), .i_m_wdata(i_m_wdata),
    .i_m_be(i_m_be), .o_m_rdata(o_m_rdata), .o_m_done(o_m_done), .o_err(o_err),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
    .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be), .i_bus_ack(i_bus_ack),
    .i_bus_rdata(i_bus_rdata), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // call at a negedge inside a bus cycle; returns at the negedge of the DONE cycle
  task automatic ack_now(input logic [31:0] rd);
    i_bus_ack   = 1'b1;
    i_bus_rdata = rd;
    @(negedge i_clk);
    i_bus_ack   = 1'b0;
    i_bus_rdata = '0;
  endtask

  initial begin
    i_reset_n = 1'b0; i_f_req = 0; i_m_req = 0; i_m_we = 0; i_bus_ack = 0;
    i_f_addr = '0; i_m_addr = '0; i_m_wdata = '0; i_bus_rdata = '0; i_m_be = '0;
    repeat (2) @(negedge i_clk);
    check("rst bus_req", o_bus_req, 0);
    check("rst busy", o_busy, 0);
    check("rst f_done", o_f_done, 0);
    check("rst m_rdata", o_m_rdata, 0);
    check("rst bus_addr", o_bus_addr, 0);
    i_reset_n = 1'b1;
    @(negedge i_clk);

    // 1: F-only read, ack on second bus cycle
    i_f_req = 1; i_f_addr = 32'h100;
    @(negedge i_clk);
    check("t1 bus_req", o_bus_req, 1);
    check("t1 bus_we", o_bus_we, 0);
    check("t1 bus_be", o_bus_be, 4'hF);
    check("t1 bus_addr", o_bus_addr, 32'h100);
    check("t1 busy", o_busy, 1);
    @(negedge i_clk);
    ack_now(32'hDEADBEEF);
    check("t1 f_done", o_f_done, 1);
    check("t1 f_rdata", o_f_rdata, 32'hDEADBEEF);
    check("t1 err", o_err, 0);
    check("t1 bus_req off", o_bus_req, 0);
    i_f_req = 0;
    @(negedge i_clk);
    check("t1 done 1cyc", o_f_done, 0);
    check("t1 idle", o_busy, 0);

    // 2: simultaneous F and M, M store wins
    i_f_req = 1; i_f_addr = 32'h300;
    i_m_req = 1; i_m_we = 1; i_m_addr = 32'h200; i_m_wdata = 32'h12345678; i_m_be = 4'h3;
    @(negedge i_clk);
    check("t2 m bus_we", o_bus_we, 1);
    check("t2 m bus_addr", o_bus_addr, 32'h200);
    check("t2 m wdata", o_bus_wdata, 32'h12345678);
    check("t2 m be", o_bus_be, 4'h3);
    ack_now(32'hAAAAAAAA);
    check("t2 m_done", o_m_done, 1);
    check("t2 f_done", o_f_done, 0);
    check("t2 store rdata", o_m_rdata, 0);
    i_m_req = 0;
    @(negedge i_clk);
    check("t2 idle gap", o_bus_req, 0);
    @(negedge i_clk);
    check("t2 f bus_addr", o_bus_addr, 32'h300);
    check("t2 f bus_we", o_bus_we, 0);
    check("t2 f bus_be", o_bus_be, 4'hF);
    ack_now(32'h0BADF00D);
    check("t2 f_rdata", o_f_rdata, 32'h0BADF00D);
    i_f_req = 0;
    @(negedge i_clk);

    // 3: F held while M re-requests; four M grants, then F forced
    i_f_req = 1; i_f_addr = 32'h400;
    i_m_req = 1; i_m_we = 0; i_m_addr = 32'h500;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      check("t3 m addr", o_bus_addr, 32'h500 + 32'(i) * 4);
      ack_now(32'h1000 + 32'(i));
      check("t3 m_done", o_m_done, 1);
      check("t3 m_rdata", o_m_rdata, 32'h1000 + 32'(i));
      i_m_addr = 32'h500 + 32'(i + 1) * 4;
      @(negedge i_clk);
    end
    @(negedge i_clk);
    check("t3 f forced", o_bus_addr, 32'h400);
    ack_now(32'hF00D);
    check("t3 f_done", o_f_done, 1);
    check("t3 f_rdata", o_f_rdata, 32'hF00D);
    @(negedge i_clk);
    @(negedge i_clk);
    check("t3 wait cleared", o_bus_addr, 32'h510);
    i_f_req = 0;
    ack_now(32'h1234);
    i_m_req = 0;
    @(negedge i_clk);

    // 4: watchdog abort after 8 bus cycles, then a normal load
    i_m_req = 1; i_m_we = 0; i_m_addr = 32'h600;
    @(negedge i_clk);
    cnt = 0;
    while (o_bus_req && cnt < 20) begin
      cnt++;
      @(negedge i_clk);
    end
    check("t4 bus cycles", cnt, 8);
    check("t4 m_done", o_m_done, 1);
    check("t4 err", o_err, 1);
    check("t4 rdata zero", o_m_rdata, 0);
    i_m_req = 0;
    @(negedge i_clk);
    check("t4 err 1cyc", o_err, 0);
    i_m_req = 1; i_m_addr = 32'h700;
    @(negedge i_clk);
    check("t4 next bus_req", o_bus_req, 1);
    ack_now(32'h77);
    check("t4 next done", o_m_done, 1);
    check("t4 next err", o_err, 0);
    check("t4 next rdata", o_m_rdata, 32'h77);
    i_m_req = 0;
    @(negedge i_clk);

    // 5: ack on the expiry cycle completes normally
    i_m_req = 1; i_m_addr = 32'h800;
    @(negedge i_clk);
    repeat (7) @(negedge i_clk);
    check("t5 still on bus", o_bus_req, 1);
    ack_now(32'h55);
    check("t5 m_done", o_m_done, 1);
    check("t5 err", o_err, 0);
    check("t5 rdata", o_m_rdata, 32'h55);
    i_m_req = 0;
    @(negedge i_clk);
    // stray ack while idle must be ignored
    i_bus_ack = 1; i_bus_rdata = 32'hBAD;
    @(negedge i_clk);
    i_bus_ack = 0;
    check("stray rdata held", o_m_rdata, 32'h55);
    check("stray no done", o_m_done, 0);
    check("stray idle", o_busy, 0);

    // 6: async reset in the middle of BUS_M
    i_m_req = 1; i_m_we = 1; i_m_addr = 32'h900;
    @(negedge i_clk);
    check("t6 on bus", o_bus_req, 1);
    #1 i_reset_n = 1'b0;
    #1 check("t6 async drop", o_bus_req, 0);
    check("t6 busy drop", o_busy, 0);
    i_m_req = 0;
    @(negedge i_clk);
    check("t6 no done", o_m_done, 0);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    check("t6 idle busy", o_busy, 0);
    check("t6 idle bus_req", o_bus_req, 0);
    check("t6 idle done", o_m_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
